// File: rtl/disp_pkg.sv
// Shared display-code definitions for the digit scanner and the downstream
// 7-segment decoder. A display code is 5 bits: 0-15 hex digit, 16 dash,
// 31 blank.
package disp_pkg;
   localparam int CODE_W = 5;

   typedef logic [CODE_W-1:0] disp_code_t;

   localparam disp_code_t CODE_DASH  = 5'd16;
   localparam disp_code_t CODE_BLANK = 5'd31;

   // Hex nibble to display code (zero-extended).
   function automatic disp_code_t hex_code(input logic [3:0] nib);
      return {1'b0, nib};
   endfunction
endpackage

// File: rtl/digit_scan_if.sv
// Bus between a host and the digit scanner.
//   load       host -> scanner  one-cycle strobe capturing value/dash_mask
//   value      host -> scanner  4*DIGITS hex nibbles, digit 0 in [3:0]
//   dash_mask  host -> scanner  bit i forces digit i to dash
//   x          scanner -> host  display code for the enabled digit
//   an         scanner -> host  active-low digit enables
//   pending    scanner -> host  loaded value waits for the next frame boundary
//   frame_tick scanner -> host  one-cycle pulse at each frame boundary
interface digit_scan_if #(parameter int DIGITS = 4);
   import disp_pkg::*;

   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dash_mask;
   disp_code_t            x;
   logic [DIGITS-1:0]     an;
   logic                  pending;
   logic                  frame_tick;

   modport master (
      output load, value, dash_mask,
      input  x, an, pending, frame_tick
   );

   modport slave (
      input  load, value, dash_mask,
      output x, an, pending, frame_tick
   );
endinterface

// File: rtl/digit_scan_tick_gen.sv
// Slot prescaler for the digit scanner: counts 0..REFRESH_DIV-1 and wraps.
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   tick     high while the count is at its terminal value (slot tick)
//   pre_tick high the cycle before tick, lets the caller register
//            outputs that must coincide with tick
module tick_gen #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick,
   output logic pre_tick
);
   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CNT_W'(1);
   end

   assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign pre_tick = (cnt == CNT_W'(REFRESH_DIV - 2));
endmodule

// File: rtl/digit_scan.sv
// Multiplexed digit scanner. A host loads a value into a shadow register;
// it is promoted to the displayed (active) register only at a frame
// boundary, so a frame never mixes old and new digits.
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   digit_scan_if slave modport (load/value/dash_mask in,
//         x/an/pending/frame_tick out, all outputs registered)
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (code 31); digit 0 and dashed digits are never blanked.
module digit_scan
   import disp_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   digit_scan_if.slave bus
);
   localparam int                IDX_W = $clog2(DIGITS);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DIGITS - 1);

   logic                        tick, pre_tick, frame_end;
   logic [IDX_W-1:0]            idx;
   logic [DIGITS-1:0][3:0]      shadow_val, active_val;
   logic [DIGITS-1:0]           shadow_dash, active_dash;
   logic                        pending_q, frame_tick_q;
   disp_code_t                  x_q;
   logic [DIGITS-1:0]           an_q;
   disp_code_t [DIGITS-1:0]     code;

   tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   assign frame_end = tick && (idx == LAST);

   // Per-digit display code from the active register.
`ifdef LEADING_ZERO_BLANK_EN
   // zero_above[i]: digit i and every higher digit are 0 and undashed.
   logic [DIGITS-1:0] zero_above;
`endif
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == DIGITS - 1) begin : g_top
         assign zero_above[gi] = (active_val[gi] == 4'd0) && !active_dash[gi];
      end else begin : g_low
         assign zero_above[gi] = (active_val[gi] == 4'd0) && !active_dash[gi]
                                 && zero_above[gi+1];
      end
      if (gi == 0) begin : g_d0
         assign code[gi] = active_dash[gi] ? CODE_DASH : hex_code(active_val[gi]);
      end else begin : g_dn
         assign code[gi] = active_dash[gi] ? CODE_DASH  :
                           zero_above[gi]  ? CODE_BLANK :
                                             hex_code(active_val[gi]);
      end
`else
      assign code[gi] = active_dash[gi] ? CODE_DASH : hex_code(active_val[gi]);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx          <= '0;
         shadow_val   <= '0;
         shadow_dash  <= '0;
         active_val   <= '0;
         active_dash  <= '0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         x_q          <= '0;
         an_q         <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else begin
         if (tick) idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);

         // Commit uses the pre-edge shadow, so a coincident load lands in
         // the shadow and stays pending for the following frame.
         if (frame_end && pending_q) begin
            active_val  <= shadow_val;
            active_dash <= shadow_dash;
         end

         if (bus.load) begin
            shadow_val  <= bus.value;
            shadow_dash <= bus.dash_mask;
            pending_q   <= 1'b1;
         end else if (frame_end) begin
            pending_q   <= 1'b0;
         end

         // Registered from pre_tick so the pulse lines up with the
         // boundary slot tick itself.
         frame_tick_q <= pre_tick && (idx == LAST);

         // Code and enable come from the same idx sample: no skew.
         x_q  <= code[idx];
         an_q <= ~(DIGITS'(1) << idx);
      end
   end

   assign bus.x          = x_q;
   assign bus.an         = an_q;
   assign bus.pending    = pending_q;
   assign bus.frame_tick = frame_tick_q;
endmodule

// File: doc/digit_scan.md
DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 Parameter: DIGITS, 4, number of multiplexed digits (2..8).
REQ-002 Parameter: REFRESH_DIV, 50000, clocks per digit slot (>=2).
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: load  input  1  one-cycle strobe; captures value and dash_mask.
REQ-006 Port: value  input  4*DIGITS  hex nibbles, digit 0 = bits [3:0] (least significant).
REQ-007 Port: dash_mask  input  DIGITS  bit i set forces digit i to dash.
REQ-008 Port: x  output  5  display code to the downstream 7-segment decoder: 0-15 hex, 16 dash, 31 blank.
REQ-009 Port: an  output  DIGITS  digit enables, active-low, exactly one bit low out of reset.
REQ-010 Port: pending  output  1  a loaded value waits for the next frame boundary.
REQ-011 Port: frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Prescaler counts 0..REFRESH_DIV-1 and wraps; its terminal count is the slot tick.
REQ-013 On a slot tick, index advances by 1, wrapping DIGITS-1 -> 0.
REQ-014 Frame boundary is a slot tick with index == DIGITS-1; frame_tick asserts that same cycle only.
REQ-015 load captures value/dash_mask into the shadow register and sets pending the following cycle.
REQ-016 load while pending: shadow is overwritten, last load wins, pending stays 1.
REQ-017 At a frame boundary with pending=1, shadow is copied to the active register and pending clears.
REQ-018 load coincident with a frame boundary: the prior shadow commits, the new data enters shadow, and pending stays 1.
REQ-019 Active register changes only at frame boundaries, so no frame mixes old and new digits.
REQ-020 x = 16 when the active dash bit of index is set, otherwise the active nibble of index zero-extended.
REQ-021 an = all ones except bit index low.
REQ-022 x, an, pending and frame_tick are registered, with no combinational path from inputs.
REQ-023 x and an update together on the cycle after index changes, so there is no skew between code and enable.

Reset
REQ-024 rst held high sets prescaler=0, index=0, shadow=0, active value=0, active dash=0, and pending=0.
REQ-025 Outputs after reset: x=5'b00000, an={DIGITS-1{1},0}, pending=0, frame_tick=0.
REQ-026 rst mid-frame or with pending=1 discards shadow and pending with no commit; the scan restarts at digit 0.
REQ-027 load in the same cycle as rst is ignored.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN is defined: digit i>0 shows code 31 when its active nibble and all higher active nibbles are 0 and none of those digits is dashed.
REQ-029 Under LEADING_ZERO_BLANK_EN, dash has priority over blanking, and digit 0 is never blanked.
REQ-030 Macro LEADING_ZERO_BLANK_EN is undefined: every digit shows its nibble or dash, and code 31 is never emitted.

Structure
REQ-031 Shared package disp_pkg holds CODE_W=5, CODE_DASH=5'd16, CODE_BLANK=5'd31, and a typedef for the 5-bit display code; the downstream decoder uses the same package.
REQ-032 One sub-module, tick_gen, holds the REFRESH_DIV prescaler and emits the slot tick; the remainder is inline.

Verification
REQ-033 All scenarios use DIGITS=4 and REFRESH_DIV=4.
REQ-034 Reset: rst for 2 cycles, then release -> x=0, an=4'b1110, pending=0; an steps 1101, 1011, 0111, 1110 every 4 clocks.
REQ-035 Frame commit: load with value=16'h1A09, dash_mask=0 mid-frame -> pending=1 until frame_tick; the next frame gives x sequence 9, 0, 10, 1 on digits 0..3, and pending=0.
REQ-036 Dash: load value=16'h0000, dash_mask=4'b0100 -> after commit, digit 2 gives x=16 and the other digits give x=0 (macro undefined).
REQ-037 Last-wins and coincident load:
- loads of 16'h1111 then 16'h2222 within one frame -> only 2s are displayed.
- load on the frame_tick cycle -> the previous shadow shows next frame, the new value the frame after.
REQ-038 Reset mid-operation: rst with pending=1 -> pending=0, the active value stays 0, and x=0 on all digits.
REQ-039 LEADING_ZERO_BLANK_EN defined, value=16'h0070 -> digits 0..3 give x=0, 7, 31, 31; value=16'h0000 -> x=0, 31, 31, 31.
